param_scan_mux: RTL and testbench

PARAM_SCAN_MUX -- requirements
Module: param_scan_mux

---
 rtl/param_scan_mux_pkg.sv | 19 +
 rtl/param_scan_mux_if.sv | 31 +++
 rtl/param_scan_mux_dwell_timer.sv | 35 +++
 rtl/param_scan_mux.sv | 102 ++++++++++
 tb/tb_param_scan_mux.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/param_scan_mux_pkg.sv
// Shared constants for the scan multiplexer: mode encodings and a ceil-log2 helper.
package param_scan_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Smallest r with 2**r >= n; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_scan_mux_if.sv
// Bus bundle for param_scan_mux.
//   master: drives en, mode, sel, din; receives y, cur_sel, chg, sel_err
//   slave : the multiplexer side
interface param_scan_mux_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4
) ();
  import param_scan_mux_pkg::*;

  localparam int unsigned SW = clog2(CHANNELS);

  logic                      en;
  logic                      mode;
  logic [SW-1:0]             sel;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          y;
  logic [SW-1:0]             cur_sel;
  logic                      chg;
  logic                      sel_err;

  modport master (
    output en, mode, sel, din,
    input  y, cur_sel, chg, sel_err
  );

  modport slave (
    input  en, mode, sel, din,
    output y, cur_sel, chg, sel_err
  );

endinterface

// File: rtl/param_scan_mux_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while en, wraps on tick; clr forces 0.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance the count
//   clr        : clear the count (wins over en)
//   tick       : count is at its terminal value DWELL-1
module dwell_timer
  import param_scan_mux_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // DWELL=1 still needs a 1-bit register; it simply stays at 0.
  localparam int unsigned CW = (DWELL > 1) ? clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/param_scan_mux.sv
// Registered channel multiplexer with manual select and timed auto-scan.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.en     : update enable (0 freezes everything, chg low)
//   bus.mode   : MODE_MANUAL uses bus.sel, MODE_SCAN steps channels every DWELL cycles
//   bus.sel    : manual channel request
//   bus.din    : flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   bus.y      : registered selected data
//   bus.cur_sel: registered index of the channel driving y
//   bus.chg    : one-cycle pulse after cur_sel changes
//   bus.sel_err: last manual request was out of range
module param_scan_mux
  import param_scan_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 4
) (
  input logic clk,
  input logic rst_n,
  param_scan_mux_if.slave bus
);

  localparam int unsigned SW   = clog2(CHANNELS);
  localparam int unsigned NPAD = 1 << SW;
  localparam int unsigned DW   = NPAD * WIDTH;

  logic [WIDTH-1:0] y_q, y_d;
  logic [SW-1:0]    cur_q, cur_d;
  logic             chg_q, chg_d;
  logic             err_q, err_d;

  logic             is_scan;
  logic             scan_en;
  logic             scan_clr;
  logic             tick;
  logic             sel_ok;
  logic [DW-1:0]    din_ext;

  assign is_scan  = (bus.mode == MODE_SCAN);
  assign scan_en  = bus.en & is_scan;
  // Any enabled manual cycle resets the dwell so a later scan starts fresh.
  assign scan_clr = bus.en & ~is_scan;
  assign sel_ok   = (32'(bus.sel) < CHANNELS);

  // Pad to a power-of-two channel count so every select value indexes in range.
  assign din_ext  = DW'(bus.din);

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (scan_en),
    .clr  (scan_clr),
    .tick (tick)
  );

  // Next-state selection for data, channel index and flags.
  always_comb begin
    y_d   = y_q;
    cur_d = cur_q;
    err_d = err_q;
    chg_d = 1'b0;
    if (bus.en) begin
      if (is_scan) begin
        if (tick) begin
          cur_d = (cur_q == SW'(CHANNELS - 1)) ? '0 : cur_q + SW'(1);
        end
        y_d   = din_ext[32'(cur_d) * WIDTH +: WIDTH];
        err_d = 1'b0;
      end else if (sel_ok) begin
        cur_d = bus.sel;
        y_d   = din_ext[32'(bus.sel) * WIDTH +: WIDTH];
        err_d = 1'b0;
      end else begin
        y_d   = '0;
        err_d = 1'b1;
      end
      chg_d = (cur_d != cur_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= '0;
      cur_q <= '0;
      chg_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      cur_q <= cur_d;
      chg_q <= chg_d;
      err_q <= err_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.cur_sel = cur_q;
  assign bus.chg     = chg_q;
  assign bus.sel_err = err_q;

endmodule

// File: tb/tb_param_scan_mux.sv
module tb_param_scan_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  param_scan_mux_if #(.WIDTH(4), .CHANNELS(4)) b0 ();
  param_scan_mux_if #(.WIDTH(4), .CHANNELS(3)) b1 ();
  param_scan_mux_if #(.WIDTH(4), .CHANNELS(4)) b2 ();

  param_scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  param_scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  param_scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  typedef struct {
    int cur;
    int cnt;
    int y;
    int err;
    int chg;
  } mst_t;

  typedef struct {
    int          id;
    string       tag;
    logic [31:0] y;
    logic [31:0] cur;
    logic [31:0] chg;
    logic [31:0] err;
  } exp_t;

  exp_t  sbq[$];
  mst_t  m0, m1, m2;
  int    total = 0;
  int    fails = 0;

  logic        en, mode;
  logic [1:0]  sel;
  logic [15:0] din;

  // Reference behaviour of one multiplexer for one clock edge.
  function automatic mst_t mstep(input mst_t m, input int ch, input int dw, input bit rst,
                                 input bit e, input bit md, input int s, input logic [15:0] d);
    mst_t n;
    n = m;
    n.chg = 0;
    if (!rst) begin
      n.cur = 0; n.cnt = 0; n.y = 0; n.err = 0;
      return n;
    end
    if (!e) return n;
    if (!md) begin
      n.cnt = 0;
      if (s < ch) begin
        n.cur = s;
        n.y   = int'((d >> (4 * s)) & 16'hF);
        n.err = 0;
      end else begin
        n.y   = 0;
        n.err = 1;
      end
    end else begin
      if (m.cnt == dw - 1) begin
        n.cnt = 0;
        n.cur = (m.cur + 1) % ch;
      end else begin
        n.cnt = m.cnt + 1;
      end
      n.y   = int'((d >> (4 * n.cur)) & 16'hF);
      n.err = 0;
    end
    n.chg = (n.cur != m.cur) ? 1 : 0;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int id, input string tag, input mst_t m);
    exp_t e;
    e.id  = id;
    e.tag = tag;
    e.y   = 32'(m.y);
    e.cur = 32'(m.cur);
    e.chg = 32'(m.chg);
    e.err = 32'(m.err);
    sbq.push_back(e);
  endtask

  // Drive current inputs to all DUTs, predict, clock once, then score.
  task automatic step(input string tag);
    exp_t e;
    logic [31:0] oy, oc, og, oe;
    b0.en = en; b0.mode = mode; b0.sel = sel; b0.din = din;
    b1.en = en; b1.mode = mode; b1.sel = sel; b1.din = din[11:0];
    b2.en = en; b2.mode = mode; b2.sel = sel; b2.din = din;
    m0 = mstep(m0, 4, 4, rst_n, en, mode, int'(sel), din);
    m1 = mstep(m1, 3, 4, rst_n, en, mode, int'(sel), {4'h0, din[11:0]});
    m2 = mstep(m2, 4, 1, rst_n, en, mode, int'(sel), din);
    push_exp(0, tag, m0);
    push_exp(1, tag, m1);
    push_exp(2, tag, m2);
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.id)
        0:       begin oy = 32'(b0.y); oc = 32'(b0.cur_sel); og = 32'(b0.chg); oe = 32'(b0.sel_err); end
        1:       begin oy = 32'(b1.y); oc = 32'(b1.cur_sel); og = 32'(b1.chg); oe = 32'(b1.sel_err); end
        default: begin oy = 32'(b2.y); oc = 32'(b2.cur_sel); og = 32'(b2.chg); oe = 32'(b2.sel_err); end
      endcase
      check($sformatf("%s.u%0d.y", e.tag, e.id), oy, e.y);
      check($sformatf("%s.u%0d.cur_sel", e.tag, e.id), oc, e.cur);
      check($sformatf("%s.u%0d.chg", e.tag, e.id), og, e.chg);
      check($sformatf("%s.u%0d.sel_err", e.tag, e.id), oe, e.err);
    end
  endtask

  initial begin
    m0 = '{0, 0, 0, 0, 0};
    m1 = m0;
    m2 = m0;
    din = 16'hDCBA;

    // Reset dominates en and mode.
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 2'd1;
    step("reset0");
    step("reset1");

    // Manual select of channel 2, then held.
    rst_n = 1'b1; mode = 1'b0; sel = 2'd2;
    step("man_sel2");
    check("man_sel2.y_C", 32'(b0.y), 32'hC);
    check("man_sel2.chg_pulse", 32'(b0.chg), 32'h1);
    step("man_hold2");
    check("man_hold2.no_chg", 32'(b0.chg), 32'h0);
    step("man_hold2b");

    // Back to channel 0, then scan through a full wrap.
    sel = 2'd0;
    step("man_sel0");
    mode = 1'b1;
    for (int i = 0; i < 18; i++) step($sformatf("scan%0d", i));

    // Freeze mid-dwell with en toggling.
    en = 1'b0; step("frz0"); step("frz1");
    en = 1'b1; step("run0");
    en = 1'b0; din = 16'h1234; step("frz2");
    en = 1'b1;
    for (int i = 0; i < 6; i++) step($sformatf("run%0d", i + 1));

    // Scan to manual, including an out-of-range request on the 3-channel unit.
    din = 16'hDCBA; mode = 1'b0; sel = 2'd3;
    step("man_sel3");
    check("man_sel3.u1_err", 32'(b1.sel_err), 32'h1);
    check("man_sel3.u1_y0", 32'(b1.y), 32'h0);
    sel = 2'd1;
    step("man_sel1");
    check("man_sel1.u1_yB", 32'(b1.y), 32'hB);
    check("man_sel1.u1_err", 32'(b1.sel_err), 32'h0);

    // Get u0 to channel 2 with count 2, then reset for one cycle mid-dwell.
    sel = 2'd2; step("man_sel2b");
    mode = 1'b1; step("pre0"); step("pre1");
    rst_n = 1'b0; step("mid_rst");
    check("mid_rst.u0_cur0", 32'(b0.cur_sel), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step($sformatf("post%0d", i));
    check("post9.u0_cur2", 32'(b0.cur_sel), 32'h2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 120; i++) begin
      rst_n = ($urandom_range(0, 24) != 0);
      en    = ($urandom_range(0, 3) != 0);
      mode  = ($urandom_range(0, 2) != 0);
      sel   = 2'($urandom_range(0, 3));
      din   = 16'($urandom());
      step($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
